// File: rtl/and3_chk_pkg.sv
// Shared definitions for the AND-gate response checker family.
//   - FSM state encoding (IDLE, RUN, DONE, FAIL)
//   - default parameter values
//   - and_ref(): reference output of an N-input AND gate
package and3_chk_pkg;

    localparam int DEF_N_IN  = 3;
    localparam int DEF_CNT_W = 8;
    localparam int MAX_N_IN  = 6;

    // State encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam logic [1:0] ST_FAIL = 2'd3;

    // Reference output: AND of the low n bits of vec.
    function automatic logic and_ref(input logic [MAX_N_IN-1:0] vec, input int unsigned n);
        logic r;
        r = 1'b1;
        for (int unsigned i = 0; i < MAX_N_IN; i++) begin
            if (i < n) r = r & vec[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/and3_response_checker_cov_tracker.sv
// cov_tracker: records which of the 2^N_IN input combinations have been seen.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   clear           synchronous clear of the coverage map
//   accept          a sample with in_vec is being consumed this cycle
//   in_vec          input combination of the sample
//   covered         bit k set once in_vec==k has been accepted
//   all_covered     every combination has been seen (registered view)
//   completing      this accepted sample fills the last hole in the map
module cov_tracker
    import and3_chk_pkg::*;
#(
    parameter int N_IN = DEF_N_IN
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               accept,
    input  logic [N_IN-1:0]    in_vec,
    output logic [2**N_IN-1:0] covered,
    output logic               all_covered,
    output logic               completing
);

    localparam int NV = 2**N_IN;

    logic [NV-1:0] hit;

    assign hit         = NV'(1) << in_vec;
    assign all_covered = &covered;
    // Lets the owning FSM move to its done state in the same cycle the
    // map becomes full, so done is visible on the cycle after acceptance.
    assign completing  = accept && (&(covered | hit));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            covered <= '0;
        end else if (clear) begin
            covered <= '0;
        end else if (accept) begin
            covered <= covered | hit;
        end
    end

endmodule

// File: rtl/and3_response_checker.sv
// and3_response_checker: checks observed outputs of an N-input AND gate
// against the reference, counts passes/failures, tracks coverage of all
// input combinations and flags done once every combination was checked.
// Optional feature macro: AND3_CHECKER_STICKY_FAIL_EN -- when defined the
// first failing sample parks the FSM in FAIL until clear.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   clear             synchronous clear back to IDLE
//   sample_valid/ready  sample handshake (ready is combinational)
//   in_vec, s_obs     gate inputs and observed output of the sample
//   pass_cnt/fail_cnt saturating counters
//   covered           per-combination coverage map
//   mismatch          one-cycle pulse per failing sample
//   first_fail_vec/valid  in_vec of the first failure
//   done              every combination covered
module and3_response_checker
    import and3_chk_pkg::*;
#(
    parameter int N_IN  = DEF_N_IN,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               sample_valid,
    output logic               sample_ready,
    input  logic [N_IN-1:0]    in_vec,
    input  logic               s_obs,
    output logic [CNT_W-1:0]   pass_cnt,
    output logic [CNT_W-1:0]   fail_cnt,
    output logic [2**N_IN-1:0] covered,
    output logic               mismatch,
    output logic [N_IN-1:0]    first_fail_vec,
    output logic               first_fail_valid,
    output logic               done
);

    logic [1:0]          state, state_nxt;
    logic                accept;
    logic                fail;
    logic                completing;
    logic                all_covered;
    logic [MAX_N_IN-1:0] vec_ext;

    assign sample_ready = (state != ST_DONE) && (state != ST_FAIL) && !clear;
    assign accept       = sample_valid && sample_ready;

    always_comb begin
        vec_ext             = '0;
        vec_ext[N_IN-1:0]   = in_vec;
    end

    assign fail = (s_obs != and_ref(vec_ext, N_IN));

    cov_tracker #(.N_IN(N_IN)) u_cov (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (clear),
        .accept      (accept),
        .in_vec      (in_vec),
        .covered     (covered),
        .all_covered (all_covered),
        .completing  (completing)
    );

    // The map only fills on the transition into DONE, and FAIL is entered
    // before the map can fill, so the full map is exactly the done flag.
    assign done = all_covered;

    // Completion wins over a simultaneous failure.
    always_comb begin
        state_nxt = state;
        if (accept) begin
            if (completing)      state_nxt = ST_DONE;
`ifdef AND3_CHECKER_STICKY_FAIL_EN
            else if (fail)       state_nxt = ST_FAIL;
`endif
            else                 state_nxt = ST_RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= ST_IDLE;
            pass_cnt         <= '0;
            fail_cnt         <= '0;
            mismatch         <= 1'b0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
        end else if (clear) begin
            state            <= ST_IDLE;
            pass_cnt         <= '0;
            fail_cnt         <= '0;
            mismatch         <= 1'b0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
        end else begin
            state    <= state_nxt;
            mismatch <= accept && fail;
            if (accept) begin
                if (fail) begin
                    if (fail_cnt != '1) fail_cnt <= fail_cnt + CNT_W'(1);
                    if (!first_fail_valid) begin
                        first_fail_vec   <= in_vec;
                        first_fail_valid <= 1'b1;
                    end
                end else if (pass_cnt != '1) begin
                    pass_cnt <= pass_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_and3_response_checker.sv
module tb_and3_response_checker;

`ifdef AND3_CHECKER_STICKY_FAIL_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear = 1'b0;
    logic       sample_valid = 1'b0;
    logic       sample_ready;
    logic [2:0] in_vec = '0;
    logic       s_obs = 1'b0;
    logic [7:0] pass_cnt, fail_cnt, covered;
    logic       mismatch;
    logic [2:0] first_fail_vec;
    logic       first_fail_valid;
    logic       done;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    and3_response_checker #(.N_IN(3), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .sample_valid(sample_valid), .sample_ready(sample_ready),
        .in_vec(in_vec), .s_obs(s_obs),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .covered(covered),
        .mismatch(mismatch), .first_fail_vec(first_fail_vec),
        .first_fail_valid(first_fail_valid), .done(done)
    );

    // One sample held across one rising edge; outputs sampled 1 time unit later.
    task automatic drive(input logic [2:0] v, input logic s);
        sample_valid = 1'b1; in_vec = v; s_obs = s;
        @(posedge clk); #1;
        sample_valid = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if ({pass_cnt, fail_cnt, covered} !== 24'h0) $display("FAIL reset_cnt: got %h exp 0", {pass_cnt, fail_cnt, covered}); else passed++;
        total++; if ({mismatch, first_fail_vec, first_fail_valid, done} !== 6'b0) $display("FAIL reset_flags: got %b exp 000000", {mismatch, first_fail_vec, first_fail_valid, done}); else passed++;
        rst_n = 1'b1;
        #1;
        total++; if (sample_ready !== 1'b1) $display("FAIL reset_ready: got %b exp 1", sample_ready); else passed++;
    endtask

    task automatic test_full_pass();
        do_clear();
        for (int v = 0; v < 8; v++) drive(3'(v), v == 7);
        total++; if (pass_cnt !== 8'd8) $display("FAIL full_pass_cnt: got %0d exp 8", pass_cnt); else passed++;
        total++; if (fail_cnt !== 8'd0) $display("FAIL full_fail_cnt: got %0d exp 0", fail_cnt); else passed++;
        total++; if (covered !== 8'hFF) $display("FAIL full_covered: got %h exp ff", covered); else passed++;
        total++; if (done !== 1'b1) $display("FAIL full_done: got %b exp 1", done); else passed++;
        total++; if (sample_ready !== 1'b0) $display("FAIL full_ready: got %b exp 0", sample_ready); else passed++;
    endtask

    task automatic test_one_fail();
        int pulses = 0;
        do_clear();
        for (int v = 0; v < 8; v++) begin
            drive(3'(v), (v == 7) || (v == 5));
            if (mismatch === 1'b1) pulses++;
            if (v == 5) begin
                total++; if (sample_ready !== !STICKY) $display("FAIL fail_ready_after: got %b exp %b", sample_ready, !STICKY); else passed++;
            end
        end
        total++; if (fail_cnt !== 8'd1) $display("FAIL one_fail_cnt: got %0d exp 1", fail_cnt); else passed++;
        total++; if (pass_cnt !== (STICKY ? 8'd5 : 8'd7)) $display("FAIL one_pass_cnt: got %0d exp %0d", pass_cnt, STICKY ? 5 : 7); else passed++;
        total++; if (pulses !== 1) $display("FAIL one_mismatch_pulses: got %0d exp 1", pulses); else passed++;
        total++; if ({first_fail_valid, first_fail_vec} !== 4'b1101) $display("FAIL one_first_fail: got %b exp 1101", {first_fail_valid, first_fail_vec}); else passed++;
        total++; if (done !== !STICKY) $display("FAIL one_done: got %b exp %b", done, !STICKY); else passed++;
    endtask

    task automatic test_last_fail();
        do_clear();
        for (int v = 0; v < 7; v++) drive(3'(v), 1'b0);
        drive(3'b111, 1'b0);
        total++; if (mismatch !== 1'b1) $display("FAIL last_mismatch: got %b exp 1", mismatch); else passed++;
        total++; if ({pass_cnt, fail_cnt} !== {8'd7, 8'd1}) $display("FAIL last_cnts: got %0d/%0d exp 7/1", pass_cnt, fail_cnt); else passed++;
        total++; if ({done, sample_ready} !== 2'b10) $display("FAIL last_done_ready: got %b exp 10", {done, sample_ready}); else passed++;
        total++; if (first_fail_vec !== 3'b111) $display("FAIL last_ffv: got %b exp 111", first_fail_vec); else passed++;
        @(posedge clk); #1;
        total++; if (mismatch !== 1'b0) $display("FAIL last_mismatch_pulse: got %b exp 0", mismatch); else passed++;
    endtask

    task automatic test_saturation();
        do_clear();
        for (int i = 0; i < 300; i++) drive(3'b011, 1'b0);
        total++; if (pass_cnt !== 8'd255) $display("FAIL sat_pass: got %0d exp 255", pass_cnt); else passed++;
        total++; if (covered !== 8'h08) $display("FAIL sat_covered: got %h exp 08", covered); else passed++;
        total++; if ({done, fail_cnt} !== 9'h0) $display("FAIL sat_done_fail: got %b/%0d exp 0/0", done, fail_cnt); else passed++;
    endtask

    task automatic test_clear();
        do_clear();
        drive(3'b000, 1'b0);
        drive(3'b001, 1'b1);
        drive(3'b010, 1'b0);
        clear = 1'b1; sample_valid = 1'b1; in_vec = 3'b011; s_obs = 1'b0;
        #1;
        total++; if (sample_ready !== 1'b0) $display("FAIL clear_ready: got %b exp 0", sample_ready); else passed++;
        @(posedge clk); #1;
        clear = 1'b0; sample_valid = 1'b0;
        total++; if ({pass_cnt, fail_cnt, covered} !== 24'h0) $display("FAIL clear_cnts: got %h exp 0", {pass_cnt, fail_cnt, covered}); else passed++;
        total++; if ({first_fail_valid, mismatch, done} !== 3'b0) $display("FAIL clear_flags: got %b exp 000", {first_fail_valid, mismatch, done}); else passed++;
        drive(3'b100, 1'b0);
        total++; if ({pass_cnt, covered} !== {8'd1, 8'h10}) $display("FAIL clear_restart: got %0d/%h exp 1/10", pass_cnt, covered); else passed++;
    endtask

    task automatic test_async_reset();
        do_clear();
        for (int v = 0; v < 4; v++) drive(3'(v), 1'b0);
        #2 rst_n = 1'b0;
        #1;
        total++; if ({pass_cnt, covered} !== 16'h0) $display("FAIL arst_immediate: got %0d/%h exp 0/00", pass_cnt, covered); else passed++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int v = 0; v < 8; v++) drive(3'(v), v == 7);
        total++; if ({done, pass_cnt, covered} !== {1'b1, 8'd8, 8'hFF}) $display("FAIL arst_rerun: got %b/%0d/%h exp 1/8/ff", done, pass_cnt, covered); else passed++;
    endtask

    task automatic test_gaps();
        do_clear();
        for (int v = 0; v < 5; v++) begin
            drive(3'(v), 1'b0);
            repeat (v % 3 + 1) @(posedge clk);
            #1;
        end
        total++; if (pass_cnt !== 8'd5) $display("FAIL gaps_pass: got %0d exp 5", pass_cnt); else passed++;
        total++; if ({done, covered} !== {1'b0, 8'h1F}) $display("FAIL gaps_cov: got %b/%h exp 0/1f", done, covered); else passed++;
    endtask

    initial begin
        test_reset();
        test_full_pass();
        test_one_fail();
        test_last_fail();
        test_saturation();
        test_clear();
        test_async_reset();
        test_gaps();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/and3_response_checker.md
# and3_response_checker

Clocked response checker for the 3-input AND gate: the receiving end of the gate's exhaustive stimulus sequence. It accepts one sample per cycle (input vector plus observed gate output) through a valid/ready handshake. Each sample is compared against the reference function s = &in_vec. The block counts passes and failures, records which of the 2^N_IN input combinations have been exercised, and signals done once every combination has been checked. It sits beside the device under test in self-checking benches and on-chip built-in self-test (BIST) wrappers.

## Interface
- N_IN, 3, number of gate inputs (2..6)
- CNT_W, 8, width of the pass and fail counters
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous clear of all state and counters back to IDLE
- sample_valid  in  1  sample present this cycle
- sample_ready  out  1  checker can accept a sample
- in_vec  in  N_IN  gate inputs applied for this sample
- s_obs  in  1  observed gate output
- pass_cnt  out  CNT_W  matching samples, saturating
- fail_cnt  out  CNT_W  mismatching samples, saturating
- covered  out  2^N_IN  bit k set once in_vec==k has been checked
- mismatch  out  1  one-cycle pulse for each failing sample
- first_fail_vec  out  N_IN  in_vec of the first failure
- first_fail_valid  out  1  first_fail_vec holds a captured value
- done  out  1  every combination has been covered

## Operation
- Clock and reset: one clock, clk. Reset is asynchronous and active-low, rst_n.
- Reset values: state=IDLE, all counters 0, covered=0, mismatch=0, first_fail_vec=0, first_fail_valid=0, done=0.
- Accept rule: a sample is accepted when sample_valid && sample_ready.
- sample_ready = (state != DONE) && (state != FAIL) && !clear. This is combinational from state and clear.
- Expected output: exp = &in_vec. A sample passes when s_obs == exp and fails otherwise.
- States:
  - IDLE → RUN on the first accepted sample.
  - RUN → DONE when the accepted sample makes covered all-ones.
  - RUN → FAIL on a failing sample, only when the macro is defined.
  - DONE or FAIL → IDLE only on clear.
- Counters saturate at 2^CNT_W−1 and never wrap. Saturation does not block coverage updates.
- Repeated input vectors are allowed. They count again, but covered is unchanged.
- first_fail_vec is captured only when first_fail_valid is 0, so later failures do not overwrite it.
- When the final uncovered vector also fails: the failure is counted, DONE takes priority over FAIL, and mismatch still pulses.
- clear has priority over a simultaneous sample. The sample is not accepted, because ready is low.
- rst_n asserted mid-run returns every output to its reset value immediately.

## Timing
- All outputs are registered. Their effect appears on the cycle after acceptance.
- Affected outputs: counters, covered, mismatch, first_fail_*, done.
- Throughput is one sample per cycle while in IDLE or RUN.
- sample_ready drops in the cycle that done (or the FAIL state) is visible. No sample is accepted in that cycle.
- The upstream source must hold in_vec and s_obs stable while sample_valid is high and sample_ready is low.

## Configuration
- Macro: AND3_CHECKER_STICKY_FAIL_EN.
- Defined: the first failing sample moves the FSM to FAIL. sample_ready goes low and counters freeze until clear. done stays 0 unless the same sample also completed coverage.
- Undefined: no FAIL state. Failures are counted and checking continues until coverage is complete.

## Structure
- Shared package and3_chk_pkg holds:
  - the state enum (IDLE, RUN, DONE, FAIL)
  - the default N_IN and CNT_W constants
  - a function computing the reference output from a vector
- One sub-module, cov_tracker. It takes N_IN, an accept strobe, in_vec and clear, and produces covered and all_covered. It is reusable for other gate checkers.
- The top level holds the FSM, the counters and the first-fail capture.

## Test plan
- Reset then 8 correct samples 000..111, one per cycle (s_obs=1 only for 111) → pass_cnt=8, fail_cnt=0, covered=8'hFF, done=1 on the cycle after the 8th sample, then ready=0.
- Same 8 samples with 101 given s_obs=1 → fail_cnt=1, pass_cnt=7, mismatch pulses once, first_fail_vec=3'b101. With the macro, ready=0 from the next cycle and pass_cnt=5.
- Vector 011 sent 300 times with CNT_W=8 → pass_cnt saturates at 255, covered=8'h08, done=0.
- clear and sample_valid high in the same cycle mid-run → sample dropped, all counters 0 the next cycle, state IDLE.
- rst_n pulsed low asynchronously mid-cycle after 4 samples → outputs zero immediately. A following sequence of 8 correct samples completes normally.
- sample_valid toggled 1-0-1 with idle gaps → only valid cycles counted, and the final pass_cnt equals the number of valid samples.
